// File: rtl/spm_pkg.sv
// Shared types and defaults for the serial-parallel multiplier sequencer.
package spm_pkg;

  localparam int unsigned XW_DEF    = 8;
  localparam int unsigned YW_DEF    = 8;
  localparam int unsigned P_LAT_DEF = 1;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StRun,
    StDone
  } spm_state_e;

  // RUN length: every product bit plus the spm output register depth.
  function automatic int unsigned run_len(input int unsigned xw, input int unsigned yw,
                                          input int unsigned p_lat);
    return xw + yw + p_lat;
  endfunction

endpackage

// File: rtl/spm_seq_ctrl_if.sv
// Operand and product valid/ready handshakes of the spm sequencer.
interface spm_seq_ctrl_if #(
  parameter int unsigned XW = 8,
  parameter int unsigned YW = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [XW-1:0]    in_x;
  logic [YW-1:0]    in_y;
  logic             out_valid;
  logic             out_ready;
  logic [XW+YW-1:0] out_p;

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_p
  );

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_p
  );

endinterface

// File: rtl/spm_deser.sv
// Serial-to-parallel product register: new bit enters at the MSB, shifts toward bit 0.
module spm_deser #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_bit,
  output logic [W-1:0] o_data
);

  logic [W-1:0] r_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
    end else if (i_clr) begin
      r_data <= '0;
    end else if (i_en) begin
      r_data <= {i_bit, r_data[W-1:1]};
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/spm_seq_ctrl.sv
// Sequencer for the spm array: loads x, clears the array, streams y LSB-first,
// and deserialises the product for a valid/ready result handshake.
module spm_seq_ctrl
  import spm_pkg::*;
#(
  parameter int unsigned XW    = XW_DEF,
  parameter int unsigned YW    = YW_DEF,
  parameter int unsigned P_LAT = P_LAT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  spm_seq_ctrl_if.slave bus,
  output logic          busy,
  output logic          spm_clr,
  output logic [XW-1:0] spm_x,
  output logic          spm_y,
  input  logic          spm_p
);

  localparam int unsigned RunLen = run_len(XW, YW, P_LAT);
  localparam int unsigned CntW   = $clog2(RunLen + 1);
  localparam int unsigned PW     = XW + YW;

  spm_state_e    r_state, w_state_nxt;
  logic [CntW-1:0] r_cnt;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [PW-1:0] w_p;

  logic w_in_ready, w_out_valid, w_busy, w_clr, w_y, w_cap_en, w_accept;

  assign w_accept = (r_state == StIdle) && bus.in_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b1;
    w_clr       = 1'b0;
    w_y         = 1'b0;
    w_cap_en    = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b0;
        if (bus.in_valid) w_state_nxt = StClear;
      end
      StClear: begin
        w_clr       = 1'b1;
        w_state_nxt = StRun;
      end
      StRun: begin
        w_y      = r_y[0];
        // The first P_LAT cycles only fill the spm output pipeline.
        w_cap_en = (r_cnt >= CntW'(P_LAT));
        if (r_cnt == CntW'(RunLen - 1)) w_state_nxt = StDone;
      end
      StDone: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_x   <= bus.in_x;
        r_y   <= bus.in_y;
        r_cnt <= '0;
      end else if (r_state == StRun) begin
        r_y   <= r_y >> 1;
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  spm_deser #(
    .W(PW)
  ) u_deser (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_accept),
    .i_en  (w_cap_en),
    .i_bit (spm_p),
    .o_data(w_p)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_p     = w_p;
  assign busy          = w_busy;
  assign spm_clr       = w_clr;
  assign spm_y         = w_y;
  // x stays on the bus between operations so the array never sees a glitch.
  assign spm_x         = r_x;

endmodule
